prog_loader_arbiter: RTL and testbench
======================================

Name: prog_loader_arbiter

Overview:
- Owns the 256x16 program memory port of the DAPA2014 core and shares it between the CPU instruction fetch and a byte-serial program loader.
- In RUN, the CPU fetches transparently.
- In a load, the CPU is held, fed a STOP instruction, and the loader writes words received over a valid/ready byte stream.
- Ends with a checksum check that either releases the CPU or latches an error.

Parameters:
- BASE_ADDR, 8'h00, first memory address written by a load; later addresses increment and wrap mod 256.
- HOLD_WORD, 16'hB800, instruction driven on cpu_data while the CPU is held (STOP encoding).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start_load  in  1  one-cycle request to begin a load; honoured only in RUN or ERR.
- rx_data  in  8  loader byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid&&rx_ready at a rising edge.
- cpu_addr  in  8  CPU fetch address (PC).
- cpu_data  out  16  instruction to CPU.
- cpu_hold  out  1  stall/hold CPU.
- mem_addr  out  8  program memory address.
- mem_wdata  out  16  program memory write data.
- mem_we  out  1  program memory write strobe, one cycle per word.
- mem_rdata  in  16  program memory read data (combinational memory).
- load_done  out  1  one-cycle pulse on successful load.
- load_err  out  1  checksum failure, level.

Behaviour:
- Reset (async, reset_n=0) gives:
  - state=RUN, rx_ready=0, cpu_hold=0, mem_we=0, load_done=0, load_err=0.
  - ptr=BASE_ADDR, cnt=0, sum=0, hi=0.
  - Memory contents are untouched.
- States are RUN, COUNT, HI, LO, WRITE, CSUM, ERR.
- RUN:
  - mem_addr=cpu_addr; cpu_data=mem_rdata, same cycle with no added latency.
  - cpu_hold=0, rx_ready=0.
  - start_load → COUNT; sum cleared, ptr=BASE_ADDR.
- All states other than RUN: cpu_hold=1, cpu_data=HOLD_WORD, mem_addr=ptr.
- COUNT:
  - rx_ready=1.
  - Accepted byte → cnt (0 means 256 words) → HI.
  - The count byte is not part of the checksum.
- HI:
  - rx_ready=1.
  - Accepted byte → hi; sum+=byte (mod 256) → LO.
- LO:
  - rx_ready=1.
  - Accepted byte → mem_wdata={hi,byte}; sum+=byte → WRITE.
- WRITE:
  - rx_ready=0, mem_we=1 for exactly this cycle, mem_addr=ptr.
  - Next: ptr+=1 (8-bit wrap), cnt-=1.
  - If cnt reaches 0 → CSUM, else → HI.
- CSUM:
  - rx_ready=1.
  - Accepted byte == sum → RUN, load_done=1 for one cycle.
  - Otherwise → ERR, load_err=1.
- ERR:
  - cpu_hold=1, rx_ready=0, load_err stays 1.
  - start_load → COUNT and clears load_err.
- No byte is consumed while rx_valid=0; states wait indefinitely.
- start_load outside RUN/ERR is ignored, with no restart mid-load.
- start_load and rx_valid in the same RUN cycle: the transition to COUNT happens; the byte is not consumed (rx_ready=0 that cycle).
- Words are written as they arrive, so an aborted or failed load leaves earlier words in memory.
- Reset mid-load returns to RUN immediately. The CPU is released, fetching from partially written memory.
- cnt=0 loads 256 words, fully wrapping ptr back to BASE_ADDR.
- All outputs are registered except cpu_data, mem_addr, and cpu_hold/rx_ready, which decode from state.
- mem_wdata is held stable through WRITE.

Test Plan:
- Reset then cpu_addr=8'h03 with mem_rdata=16'hD101 → cpu_data=16'hD101, cpu_hold=0, rx_ready=0, all flags 0.
- Normal load, BASE_ADDR=0:
  - start_load, bytes 02,01,08,B8,00,C1.
  - → mem_we pulses at addr 00 (wdata 16'h0108) and 01 (16'hB800).
  - → load_done pulse, state RUN, cpu_hold falls.
  - cpu_data=HOLD_WORD throughout the load.
- Bad checksum: same stream with final byte C2 → ERR, load_err=1, cpu_hold=1. A second start_load clears load_err and accepts a new count.
- Backpressure/gaps:
  - Deassert rx_valid randomly → no byte lost or duplicated.
  - rx_ready=0 during every WRITE cycle.
  - Writes identical to the gap-free run.
- Wrap: BASE_ADDR=8'hFF, count 02 → writes at FF then 00. Count 00 with 256 words → 256 mem_we pulses, final ptr=BASE_ADDR.
- Reset mid-load: assert reset_n=0 after the 3rd byte → outputs to reset values asynchronously, cpu_hold=0, first word not written. start_load during HI is ignored.

Source files
------------

// File: rtl/prog_loader_arbiter.sv
// prog_loader_arbiter
// Owns the 256x16 program memory port of the DAPA2014 core. In RUN the CPU
// fetches straight through to memory. A load holds the CPU on a STOP word,
// receives a count byte followed by hi/lo byte pairs over a valid/ready byte
// stream, writes one word per pair, and finishes with a checksum byte that
// either releases the CPU or parks the block in ERR with load_err raised.
module prog_loader_arbiter #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [15:0] HOLD_WORD = 16'hB800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_load,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_hold,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ptr_q,   ptr_d;    // next memory address to write
  logic [8:0]  cnt_q,   cnt_d;    // words still to receive; 9 bits so 256 fits
  logic [7:0]  sum_q,   sum_d;    // running mod-256 sum of data bytes
  logic [7:0]  hi_q,    hi_d;     // high byte of the word being assembled
  logic [15:0] wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic        in_run;
  logic        accept;

  // Decode the state-only outputs: CPU pass-through in RUN, hold otherwise
  always_comb begin
    in_run   = (state_q == S_RUN);
    rx_ready = (state_q == S_COUNT) || (state_q == S_HI) ||
               (state_q == S_LO)    || (state_q == S_CSUM);
    cpu_hold = !in_run;
    cpu_data = in_run ? mem_rdata : HOLD_WORD;
    mem_addr = in_run ? cpu_addr  : ptr_q;
  end

  // A byte moves only when both sides agree at the clock edge
  assign accept = rx_valid && rx_ready;

  // Next-state and datapath updates for the load sequence
  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_RUN: begin
        // rx_ready is low here, so a byte offered alongside start_load waits
        // for COUNT instead of being swallowed.
        if (start_load) begin
          state_d = S_COUNT;
          sum_d   = 8'h00;
          ptr_d   = BASE_ADDR;
        end
      end

      S_COUNT: begin
        if (accept) begin
          // A count of zero stands for a full 256-word image.
          cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_LO;
        end
      end

      S_LO: begin
        if (accept) begin
          wdata_d = {hi_q, rx_data};
          sum_d   = sum_q + rx_data;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // The strobe registered on entry is high for this one cycle while
        // mem_addr still shows the old pointer; advance both counters now.
        ptr_d   = ptr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_CSUM : S_HI;
      end

      S_CSUM: begin
        if (accept) begin
          if (rx_data == sum_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      S_ERR: begin
        if (start_load) begin
          state_d = S_COUNT;
          err_d   = 1'b0;
          sum_d   = 8'h00;
          ptr_d   = BASE_ADDR;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State and datapath registers; reset drops straight back to RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      ptr_q   <= BASE_ADDR;
      cnt_q   <= 9'd0;
      sum_q   <= 8'h00;
      hi_q    <= 8'h00;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block above.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Bench for prog_loader_arbiter. Two instances share all stimulus: one with
// BASE_ADDR=00 and one with BASE_ADDR=FF, each backed by its own 256x16
// combinational memory. Expected writes and outcomes come from a word-list
// model of the load protocol.
module tb_prog_loader_arbiter;

  localparam logic [7:0]  BASE0 = 8'h00;
  localparam logic [7:0]  BASE1 = 8'hFF;
  localparam logic [15:0] HOLD  = 16'hB800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cpu_addr;

  logic        rx_ready0, rx_ready1;
  logic [15:0] cpu_data0, cpu_data1;
  logic        cpu_hold0, cpu_hold1;
  logic [7:0]  mem_addr0, mem_addr1;
  logic [15:0] mem_wdata0, mem_wdata1;
  logic        mem_we0, mem_we1;
  logic [15:0] rdata0, rdata1;
  logic        load_done0, load_done1;
  logic        load_err0, load_err1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t wq0[$];
  wr_t wq1[$];

  logic [15:0] load_words[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ready_bad = 0;
  int hold_bad  = 0;
  int lock_bad  = 0;

  always #5 clk = ~clk;

  prog_loader_arbiter #(.BASE_ADDR(BASE0), .HOLD_WORD(HOLD)) dut0 (
    .clk(clk), .reset_n(rst_n), .start_load(start_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data0), .cpu_hold(cpu_hold0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
    .mem_rdata(rdata0), .load_done(load_done0), .load_err(load_err0)
  );

  prog_loader_arbiter #(.BASE_ADDR(BASE1), .HOLD_WORD(HOLD)) dut1 (
    .clk(clk), .reset_n(rst_n), .start_load(start_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data1), .cpu_hold(cpu_hold1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .mem_rdata(rdata1), .load_done(load_done1), .load_err(load_err1)
  );

  assign rdata0 = mem0[mem_addr0];
  assign rdata1 = mem1[mem_addr1];

  // Memory models and write capture
  always @(posedge clk) begin
    if (mem_we0) begin
      mem0[mem_addr0] = mem_wdata0;
      wq0.push_back('{a: mem_addr0, d: mem_wdata0});
    end
    if (mem_we1) begin
      mem1[mem_addr1] = mem_wdata1;
      wq1.push_back('{a: mem_addr1, d: mem_wdata1});
    end
  end

  // Continuous protocol observations, tallied and checked later
  always @(negedge clk) begin
    if (mem_we0 && rx_ready0) ready_bad++;
    if (cpu_hold0 && cpu_data0 !== HOLD) hold_bad++;
    if (cpu_hold1 && cpu_data1 !== HOLD) hold_bad++;
    if (rx_ready0 !== rx_ready1 || cpu_hold0 !== cpu_hold1 ||
        mem_we0 !== mem_we1 || load_done0 !== load_done1 ||
        load_err0 !== load_err1) lock_bad++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Offer one byte after an optional random gap; returns at the negedge
  // following the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready0 !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("rx_ready_timeout");
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Full load of load_words; expectations come from the word list alone.
  task automatic do_load(input logic [7:0] cnt_byte, input bit corrupt,
                         input int max_gap, input bit poke_hi, input string tag);
    int n;
    int t;
    int bad0;
    int bad1;
    logic [7:0] sum;
    logic [7:0] csum;
    logic [15:0] w;
    n = (cnt_byte == 8'h00) ? 256 : int'(cnt_byte);
    sum = 8'h00;
    foreach (load_words[i]) begin
      w = load_words[i];
      sum = sum + w[15:8] + w[7:0];
    end
    csum = corrupt ? sum + 8'h01 : sum;
    wq0.delete();
    wq1.delete();

    // Present the count byte together with start_load
    start_load = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = cnt_byte;
    @(negedge clk);
    start_load = 1'b0;
    check({tag, " started_hold"}, 32'(cpu_hold0), 32'd1);
    check({tag, " started_err_clr"}, 32'(load_err0), 32'd0);
    send_byte(cnt_byte, 0);

    if (poke_hi) begin
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
    end

    for (int i = 0; i < n; i++) begin
      w = load_words[i];
      send_byte(w[15:8], max_gap);
      send_byte(w[7:0], max_gap);
    end

    t = 0;
    while (rx_ready0 !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now({tag, " csum_wait"});
    check({tag, " ptr0_at_csum"}, 32'(mem_addr0), 32'(8'(BASE0 + 8'(n))));
    check({tag, " ptr1_at_csum"}, 32'(mem_addr1), 32'(8'(BASE1 + 8'(n))));

    send_byte(csum, max_gap);
    if (!corrupt) begin
      check({tag, " load_done"}, 32'(load_done0), 32'd1);
      check({tag, " hold_released"}, 32'(cpu_hold0), 32'd0);
      check({tag, " no_err"}, 32'(load_err0), 32'd0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(load_done0), 32'd0);
    end else begin
      check({tag, " load_err"}, 32'(load_err0), 32'd1);
      check({tag, " err_hold"}, 32'(cpu_hold0), 32'd1);
      check({tag, " no_done"}, 32'(load_done0), 32'd0);
      @(negedge clk);
      check({tag, " err_level"}, 32'(load_err0), 32'd1);
    end

    check({tag, " writes0_n"}, 32'(wq0.size()), 32'(n));
    check({tag, " writes1_n"}, 32'(wq1.size()), 32'(n));
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < n; i++) begin
      if (i < wq0.size())
        if (wq0[i].a !== 8'(BASE0 + 8'(i)) || wq0[i].d !== load_words[i]) bad0++;
      if (i < wq1.size())
        if (wq1[i].a !== 8'(BASE1 + 8'(i)) || wq1[i].d !== load_words[i]) bad1++;
    end
    check({tag, " writes0_bad"}, 32'(bad0), 32'd0);
    check({tag, " writes1_bad"}, 32'(bad1), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } run_vec_t;

  run_vec_t run_tbl[5];

  initial begin
    int n;
    bit corrupt;

    run_tbl[0] = '{addr: 8'h03, data: 16'hD101};
    run_tbl[1] = '{addr: 8'h00, data: 16'h1234};
    run_tbl[2] = '{addr: 8'hFF, data: 16'hBEEF};
    run_tbl[3] = '{addr: 8'h80, data: 16'h0F0F};
    run_tbl[4] = '{addr: 8'h01, data: 16'hB800};

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    foreach (run_tbl[i]) begin
      mem0[run_tbl[i].addr] = run_tbl[i].data;
      mem1[run_tbl[i].addr] = run_tbl[i].data;
    end

    rst_n      = 1'b0;
    start_load = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    cpu_addr   = 8'h03;
    #1;
    check("reset cpu_data", 32'(cpu_data0), 32'h0000D101);
    check("reset cpu_hold", 32'(cpu_hold0), 32'd0);
    check("reset rx_ready", 32'(rx_ready0), 32'd0);
    check("reset mem_we", 32'(mem_we0), 32'd0);
    check("reset load_done", 32'(load_done0), 32'd0);
    check("reset load_err", 32'(load_err0), 32'd0);
    check("reset mem_addr", 32'(mem_addr0), 32'h03);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RUN pass-through vectors
    foreach (run_tbl[i]) begin
      cpu_addr = run_tbl[i].addr;
      #1;
      check($sformatf("run_fetch[%0d] data", i), 32'(cpu_data0), 32'(run_tbl[i].data));
      check($sformatf("run_fetch[%0d] addr", i), 32'(mem_addr0), 32'(run_tbl[i].addr));
      check($sformatf("run_fetch[%0d] hold", i), 32'(cpu_hold0), 32'd0);
    end
    @(negedge clk);

    // Reference two-word load and its bad-checksum twin
    load_words = '{16'h0108, 16'hB800};
    do_load(8'h02, 1'b0, 0, 1'b0, "normal");
    do_load(8'h02, 1'b1, 0, 1'b0, "badsum");

    // Recovery from ERR with a fresh count
    load_words = '{16'h1111, 16'h2222, 16'h3333};
    do_load(8'h03, 1'b0, 0, 1'b0, "after_err");

    // Same image with and without gaps on rx_valid
    load_words = '{16'hA5C3, 16'h0001, 16'hFFFE, 16'h7E81};
    do_load(8'h04, 1'b0, 0, 1'b0, "nogap");
    do_load(8'h04, 1'b0, 4, 1'b0, "gaps");

    // Randomized loads, some with corrupted checksums
    for (int k = 0; k < 10; k++) begin
      n = int'($urandom_range(1, 9));
      corrupt = ($urandom_range(0, 3) == 0);
      load_words.delete();
      for (int i = 0; i < n; i++) load_words.push_back(16'($urandom));
      do_load(8'(n), corrupt, 3, 1'b0, $sformatf("rand%0d", k));
    end

    // Full 256-word image wraps the pointer back to the base
    load_words.delete();
    for (int i = 0; i < 256; i++) load_words.push_back(16'($urandom));
    do_load(8'h00, 1'b0, 0, 1'b0, "full256");

    // Reset after the third byte: the first word must not reach memory
    mem0[BASE0] = 16'hAAAA;
    mem1[BASE1] = 16'hAAAA;
    wq0.delete();
    wq1.delete();
    cpu_addr   = BASE0;
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    check("midreset pre we", 32'(mem_we0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset hold", 32'(cpu_hold0), 32'd0);
    check("midreset rx_ready", 32'(rx_ready0), 32'd0);
    check("midreset mem_we", 32'(mem_we0), 32'd0);
    check("midreset load_done", 32'(load_done0), 32'd0);
    check("midreset load_err", 32'(load_err0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset mem0 untouched", 32'(mem0[BASE0]), 32'h0000AAAA);
    check("midreset mem1 untouched", 32'(mem1[BASE1]), 32'h0000AAAA);
    check("midreset no writes", 32'(wq0.size()), 32'd0);
    check("midreset cpu fetch", 32'(cpu_data0), 32'h0000AAAA);
    @(negedge clk);

    // start_load while waiting for a HI byte must not restart the load
    load_words = '{16'h1234};
    do_load(8'h01, 1'b0, 0, 1'b1, "poke_hi");

    check("rx_ready_during_write", 32'(ready_bad), 32'd0);
    check("hold_word_while_held", 32'(hold_bad), 32'd0);
    check("instances_lockstep", 32'(lock_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
